// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32i instruction-fetch stage.
package fetch_stage_pkg;

    // Fetch control states: BOOT settles the PC after reset, RUN fetches,
    // HALT freezes everything after a bad fetch address until reset.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // addi x0,x0,0 -- the bubble placed in IF/ID when no real instruction moves.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    // Default PC loaded on reset.
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // Clock period used by benches.
    localparam int CLOCK_PERIOD = 10;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Bubble,
    input  logic        Hold,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus4_D,
    output logic        Valid_D
);

    // Register the fetched word, or clear it to a bubble, or keep it.
    always_ff @(posedge CLK) begin
        if (RST || Bubble) begin
            Instr_D    <= NOP_INSTR;
            PC_D       <= 32'd0;
            PC_Plus4_D <= 32'd0;
            Valid_D    <= 1'b0;
        end else if (!Hold) begin
            Instr_D    <= Instr_F;
            PC_D       <= PC_F;
            PC_Plus4_D <= PC_F + 32'd4;
            Valid_D    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the BOOT/RUN/HALT control and fault
// detection, and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = fetch_stage_pkg::RESET_VECTOR,
    parameter int          IMEM_DEPTH   = 256,
    parameter logic [31:0] NOP_INSTR    = fetch_stage_pkg::NOP_INSTR
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Stall_F,
    input  logic         Stall_D,
    input  logic         Flush_D,
    input  logic         PC_Src,
    input  logic [31:0]  PC_Target,
    input  logic [31:0]  Instr,
    output logic [31:0]  PC_Out,
    output logic [31:0]  Instr_D,
    output logic [31:0]  PC_D,
    output logic [31:0]  PC_Plus4_D,
    output logic         Valid_D,
    output logic         Fetch_Fault,
    output fetch_state_t State_Dbg
);

    fetch_state_t state_q;
    fetch_state_t state_n;
    logic [31:0]  pc_q;
    logic [31:0]  pc_n;
    logic         ifid_bubble;
    logic         ifid_hold;
    logic         redirect_fault;
    logic         range_fault;

    // A redirect must land on a word boundary; the PC itself must stay
    // inside instruction memory.
    assign redirect_fault = PC_Src && (PC_Target[1:0] != 2'b00);
    assign range_fault    = (pc_q[31:2] >= 30'(IMEM_DEPTH));

    // Next-state, next-PC and IF/ID control; IF/ID defaults to a bubble.
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        ifid_bubble = 1'b1;
        ifid_hold   = 1'b0;
        case (state_q)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (redirect_fault || range_fault) begin
                    state_n = HALT;
                end else begin
                    if (PC_Src) begin
                        pc_n = PC_Target;
                    end else if (!Stall_F) begin
                        pc_n = pc_q + 32'd4;
                    end
                    // Wrong-path words (redirect) and repeated words (PC stall)
                    // become bubbles unless IF/ID itself is held.
                    ifid_bubble = Flush_D || (!Stall_D && (PC_Src || Stall_F));
                    ifid_hold   = Stall_D;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    // PC and control-state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
        end
    end

    assign PC_Out      = pc_q;
    assign Fetch_Fault = (state_q == HALT);
    assign State_Dbg   = state_q;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .CLK        (CLK),
        .RST        (RST),
        .Bubble     (ifid_bubble),
        .Hold       (ifid_hold),
        .Instr_F    (Instr),
        .PC_F       (pc_q),
        .Instr_D    (Instr_D),
        .PC_D       (PC_D),
        .PC_Plus4_D (PC_Plus4_D),
        .Valid_D    (Valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, expected IF/ID transfers queued
// by the driver and consumed by an independent monitor.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         RST;
  logic         Stall_F;
  logic         Stall_D;
  logic         Flush_D;
  logic         PC_Src;
  logic [31:0]  PC_Target;
  logic [31:0]  Instr;
  logic [31:0]  PC_Out;
  logic [31:0]  Instr_D;
  logic [31:0]  PC_D;
  logic [31:0]  PC_Plus4_D;
  logic         Valid_D;
  logic         Fetch_Fault;
  fetch_state_t State_Dbg;

  always #(CLOCK_PERIOD / 2) CLK = ~CLK;

  fetch_stage #(
    .RESET_VECTOR (32'h0000_0000),
    .IMEM_DEPTH   (256),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Flush_D     (Flush_D),
    .PC_Src      (PC_Src),
    .PC_Target   (PC_Target),
    .Instr       (Instr),
    .PC_Out      (PC_Out),
    .Instr_D     (Instr_D),
    .PC_D        (PC_D),
    .PC_Plus4_D  (PC_Plus4_D),
    .Valid_D     (Valid_D),
    .Fetch_Fault (Fetch_Fault),
    .State_Dbg   (State_Dbg)
  );

  // Instruction memory: word i holds 32'hC0DE_0000 + i.
  logic [31:0] mem [0:255];
  assign Instr = (PC_Out[31:10] == 22'd0) ? mem[PC_Out[9:2]] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];   // {PC_D, Instr_D, PC_Plus4_D}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr, pc + 32'd4});
  endtask

  // Monitor: every new IF/ID transfer (valid, not a held cycle) must match
  // the oldest queued expectation.
  initial begin
    bit held;
    logic [95:0] e;
    forever begin
      @(posedge CLK);
      held = Stall_D && !Flush_D && !RST;
      @(negedge CLK);
      if (Valid_D === 1'b1 && !held) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: PC_D %h Instr_D %h with no transfer expected", PC_D, Instr_D);
        end else begin
          e = exp_q.pop_front();
          if ({PC_D, Instr_D, PC_Plus4_D} !== e) begin
            errors++;
            $display("FAIL ifid_transfer: got PC_D %h Instr_D %h PC_Plus4_D %h expected %h %h %h",
                     PC_D, Instr_D, PC_Plus4_D, e[95:64], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic src, input logic [31:0] tgt,
                     input logic sf, input logic sd, input logic fl);
    PC_Src    = src;
    PC_Target = tgt;
    Stall_F   = sf;
    Stall_D   = sd;
    Flush_D   = fl;
    @(posedge CLK);
    #2;
  endtask

  task automatic run();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog.
  initial begin
    #(CLOCK_PERIOD * 5000);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    RST = 1'b1; PC_Src = 1'b0; PC_Target = 32'd0;
    Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0;

    // Reset state.
    @(posedge CLK); #2;
    chk("rst_pc", PC_Out, 32'h0);
    chk("rst_instr", Instr_D, 32'h0000_0013);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_pc4_d", PC_Plus4_D, 32'h0);
    chk("rst_valid", 32'(Valid_D), 32'd0);
    chk("rst_fault", 32'(Fetch_Fault), 32'd0);
    chk("rst_state", 32'(State_Dbg), 32'(BOOT));

    // BOOT cycle: PC holds, bubble stays.
    RST = 1'b0;
    run();
    chk("boot_pc", PC_Out, 32'h0);
    chk("boot_valid", 32'(Valid_D), 32'd0);
    chk("boot_state", 32'(State_Dbg), 32'(RUN));

    // Sequential fetch 0x0..0xC.
    for (int k = 0; k < 4; k++) begin
      push_exp(32'(k * 4), mem[k]);
      run();
      chk("seq_pc", PC_Out, 32'((k + 1) * 4));
    end

    // Redirect at PC 0x10 to 0x40.
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    chk("redir_pc", PC_Out, 32'h40);
    chk("redir_valid", 32'(Valid_D), 32'd0);
    chk("redir_instr", Instr_D, 32'h0000_0013);
    push_exp(32'h40, 32'hC0DE_0010);
    run();
    chk("redir_next_pc", PC_Out, 32'h44);
    for (int k = 1; k < 10; k++) begin
      push_exp(32'h40 + 32'(4 * k), mem[16 + k]);
      run();
      chk("seq2_pc", PC_Out, 32'h44 + 32'(4 * k));
    end

    // Stall both stages at PC 0x8 with IF/ID holding PC 0x4.
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
    push_exp(32'h4, 32'hC0DE_0001);
    run();
    chk("pre_stall_pc", PC_Out, 32'h8);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      chk("stall_pc", PC_Out, 32'h8);
      chk("stall_pc_d", PC_D, 32'h4);
      chk("stall_instr", Instr_D, 32'hC0DE_0001);
      chk("stall_valid", 32'(Valid_D), 32'd1);
    end

    // Flush beats Stall_D.
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("flush_instr", Instr_D, 32'h0000_0013);
    chk("flush_valid", 32'(Valid_D), 32'd0);
    chk("flush_pc_d", PC_D, 32'h0);
    chk("flush_pc", PC_Out, 32'h8);
    push_exp(32'h8, 32'hC0DE_0002);
    run();
    chk("resume_pc", PC_Out, 32'hC);

    // Stall_F alone: PC holds and IF/ID gets a bubble (no duplicate).
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("stallf_pc", PC_Out, 32'hC);
    chk("stallf_valid", 32'(Valid_D), 32'd0);
    push_exp(32'hC, 32'hC0DE_0003);
    run();
    chk("stallf_resume_pc", PC_Out, 32'h10);

    // Redirect beats Stall_F.
    cyc(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    chk("redir_stall_pc", PC_Out, 32'h20);
    chk("redir_stall_valid", 32'(Valid_D), 32'd0);
    push_exp(32'h20, 32'hC0DE_0008);
    run();
    chk("redir_stall_next", PC_Out, 32'h24);

    // Flush alone: PC keeps advancing, IF/ID bubbles.
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_only_pc", PC_Out, 32'h28);
    chk("flush_only_valid", 32'(Valid_D), 32'd0);

    // Reset mid-run at PC 0x1C during a stall.
    cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
    push_exp(32'h18, 32'hC0DE_0006);
    run();
    chk("pre_rst_pc", PC_Out, 32'h1C);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_hold", PC_Out, 32'h1C);
    RST = 1'b1;
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("midrst_pc", PC_Out, 32'h0);
    chk("midrst_valid", 32'(Valid_D), 32'd0);
    chk("midrst_fault", 32'(Fetch_Fault), 32'd0);
    chk("midrst_instr", Instr_D, 32'h0000_0013);
    RST = 1'b0;
    run();
    chk("midrst_boot_valid", 32'(Valid_D), 32'd0);
    push_exp(32'h0, 32'hC0DE_0000);
    run();
    chk("midrst_first_valid", 32'(Valid_D), 32'd1);
    chk("midrst_pc_after", PC_Out, 32'h4);

    // Misaligned redirect: fault, PC frozen, bubbles until reset.
    cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    chk("rfault_flag", 32'(Fetch_Fault), 32'd1);
    chk("rfault_pc", PC_Out, 32'h4);
    chk("rfault_valid", 32'(Valid_D), 32'd0);
    chk("rfault_state", 32'(State_Dbg), 32'(HALT));
    for (int k = 0; k < 5; k++) begin
      if (k == 1) cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      else if (k == 2) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      else run();
      chk("halt_flag", 32'(Fetch_Fault), 32'd1);
      chk("halt_pc", PC_Out, 32'h4);
      chk("halt_valid", 32'(Valid_D), 32'd0);
    end

    // Range fault: full sequential run from reset up to PC 0x400.
    RST = 1'b1;
    run();
    chk("rst2_fault", 32'(Fetch_Fault), 32'd0);
    RST = 1'b0;
    run();
    for (int k = 0; k < 256; k++) begin
      push_exp(32'(4 * k), mem[k]);
      run();
      chk("long_seq_pc", PC_Out, 32'(4 * (k + 1)));
    end
    chk("range_edge_no_fault", 32'(Fetch_Fault), 32'd0);
    run();
    chk("range_fault_flag", 32'(Fetch_Fault), 32'd1);
    chk("range_fault_pc", PC_Out, 32'h400);
    chk("range_fault_valid", 32'(Valid_D), 32'd0);
    run();
    chk("range_halt_pc", PC_Out, 32'h400);
    chk("range_halt_flag", 32'(Fetch_Fault), 32'd1);

    // Every queued transfer must have been seen.
    @(negedge CLK); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch initiator for the RV32i pipeline. It owns the PC register, drives PC_Out into instruction_memory, and samples the combinational Instr return.
- Registers the fetched word into the IF/ID pipeline register, with stall, flush and branch-redirect control from the hazard unit and the execute stage.
- Flags misaligned or out-of-range fetch addresses and halts fetch until reset.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- IMEM_DEPTH, 256: instruction memory size in 32-bit words; legal fetch range is PC[31:2] < IMEM_DEPTH.
- NOP_INSTR, 32'h0000_0013: bubble inserted into IF/ID (addi x0,x0,0).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- Stall_F  in  1  hold the PC.
- Stall_D  in  1  hold the IF/ID register.
- Flush_D  in  1  replace IF/ID contents with a bubble.
- PC_Src  in  1  redirect request (branch taken / jump) from execute.
- PC_Target  in  32  redirect target address.
- Instr  in  32  instruction word from instruction_memory (combinational from PC_Out).
- PC_Out  out  32  fetch address to instruction_memory.
- Instr_D  out  32  IF/ID instruction.
- PC_D  out  32  IF/ID PC of that instruction.
- PC_Plus4_D  out  32  IF/ID PC+4.
- Valid_D  out  1  IF/ID holds a real instruction.
- Fetch_Fault  out  1  sticky fault flag.

Behaviour:
- One clock, CLK. Reset RST is synchronous and active-high; all state updates occur on the rising edge of CLK.
- Reset values:
  - PC_Out = RESET_VECTOR
  - Instr_D = NOP_INSTR
  - PC_D = 0
  - PC_Plus4_D = 0
  - Valid_D = 0
  - Fetch_Fault = 0
  - FSM = BOOT
- FSM states:
  - BOOT: one cycle after reset. PC holds and IF/ID stays a bubble, so memory sees a stable PC. Next state is RUN.
  - RUN: normal fetch.
  - HALT: entered on fault. PC holds, IF/ID is forced to bubble every cycle, Fetch_Fault = 1. Only RST exits.
- PC update in RUN, in priority order:
  1. PC_Src=1: PC <= PC_Target. Redirect beats Stall_F.
  2. Stall_F=1: PC holds.
  3. Otherwise: PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0, which is then range-checked normally.
- Fault detection (RUN only):
  - Redirect fault: PC_Src=1 with PC_Target[1:0] != 0 → next state HALT, PC holds, IF/ID bubble.
  - Range fault: PC_Out[31:2] >= IMEM_DEPTH → next state HALT. The current word is not captured (Valid_D <= 0).
  - If both occur in the same cycle, the fault is still raised once. Fetch_Fault goes to 1 the cycle after detection.
- IF/ID update in RUN, in priority order:
  1. Flush_D=1: bubble (Instr_D=NOP_INSTR, Valid_D=0, PC_D/PC_Plus4_D=0). Flush beats Stall_D.
  2. Stall_D=1: hold all IF/ID fields.
  3. PC_Src=1 (no flush asserted): capture a bubble, because the word at PC_Out is wrong-path.
  4. Stall_F=1 with Stall_D=0: capture a bubble, so no duplicate issue.
  5. Otherwise: Instr_D <= Instr, PC_D <= PC_Out, PC_Plus4_D <= PC_Out+4, Valid_D <= 1.
- Latency: a PC presented on PC_Out appears on Instr_D one cycle later. First valid instruction is 2 cycles after RST deasserts (BOOT + fetch).
- RST asserted mid-operation: all state returns to reset values on that edge regardless of any other input, including from HALT.
- PC_Out[1:0] is always 0 outside HALT.

Decomposition:
- Into the shared definitions package:
  - fetch_state_t enum {BOOT, RUN, HALT}
  - NOP_INSTR constant
  - RESET_VECTOR default
- CLOCK_PERIOD already lives in that package for benches.
- One natural sub-module, if_id_register: holds the IF/ID pipeline register with stall/flush/bubble priority. fetch_stage keeps the PC, FSM and fault logic.

Test Plan:
- Sequential fetch: reset, memory preloaded with program.hex, no stalls for 10 cycles → PC_Out steps 0,4,8,...; Instr_D equals word[PC_D[31:2]] each cycle from cycle 2; Valid_D=1 from cycle 2.
- Redirect: PC_Src=1, PC_Target=32'h40 while PC_Out=32'h10 → next PC_Out=32'h40; Instr_D bubble (Valid_D=0) for that cycle; following cycle Instr_D=word[16], PC_D=32'h40.
- Stall/flush priority:
  - Stall_F=Stall_D=1 for 3 cycles at PC_Out=32'h8 → PC_Out and IF/ID held unchanged.
  - Flush_D=1 with Stall_D=1 → Instr_D=32'h0000_0013, Valid_D=0.
- Redirect vs stall: PC_Src=1, Stall_F=1, PC_Target=32'h20 → PC_Out=32'h20 next cycle.
- Faults:
  - PC_Src=1, PC_Target=32'h22 → Fetch_Fault=1 next cycle, PC_Out frozen, Valid_D stays 0 for 5 cycles.
  - Separately, sequential run reaching PC_Out=32'h400 (IMEM_DEPTH=256) → HALT.
- Reset mid-run: assert RST at PC_Out=32'h1C during a stall → next edge PC_Out=0, Valid_D=0, Fetch_Fault=0; first valid Instr_D 2 cycles after RST drops.
